// File: rtl/tl2chi_pkg.sv
// rtl/tl2chi_pkg.sv - shared TileLink-to-CHI link states and CHI field constants
package tl2chi_pkg;

  typedef enum logic [1:0] {STOP, ACTIVATE, RUN, DEACTIVATE} link_state_e;

  localparam int TXNID_W = 8;
  localparam logic [6:0] REQ_LCRDRETURN_OPCODE = 7'h00;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first requester at or above ptr_i, wrapping
module rr_arbiter #(
  parameter int NUM_ENTRIES = 4,
  localparam int IDX_W = $clog2(NUM_ENTRIES)
) (
  input  logic [NUM_ENTRIES-1:0] req_i,
  input  logic [IDX_W-1:0]       ptr_i,
  input  logic                   en_i,
  output logic [NUM_ENTRIES-1:0] gnt_o,
  output logic [IDX_W-1:0]       idx_o
);

  always_comb begin : sel
    logic             found;
    logic [IDX_W-1:0] cand;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 0; off < NUM_ENTRIES; off++) begin
      cand = IDX_W'((int'(ptr_i) + off) % NUM_ENTRIES);
      if (en_i && !found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/tl2chi_txreq_sched.sv
// rtl/tl2chi_txreq_sched.sv - shares CHI TXREQ among transaction entries
// Owns the TX link FSM, the L-credit counter and the registered outgoing flit.
module tl2chi_txreq_sched
  import tl2chi_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int FLIT_W      = 100,
  parameter int TXNID_LSB   = 4,
  parameter int MAX_CRD     = 15,
  localparam int CRD_W      = $clog2(MAX_CRD + 1),
  localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          link_en,
  input  logic [NUM_ENTRIES-1:0]        entry_txreq_valid,
  input  logic [NUM_ENTRIES*FLIT_W-1:0] entry_txreq_flit,
  output logic [NUM_ENTRIES-1:0]        entry_txreq_ready,
  output logic                          txreq_flitpend,
  output logic                          txreq_flitv,
  output logic [FLIT_W-1:0]             txreq_flit,
  input  logic                          txreq_lcrdv,
  output logic                          txlinkactivereq,
  input  logic                          txlinkactiveack,
  output logic                          link_run,
  output logic                          crd_overflow
);

  // Opcode and TxnID of a credit-return flit are both zero, so the whole flit is zero.
  localparam logic [FLIT_W-1:0] RET_FLIT = FLIT_W'(REQ_LCRDRETURN_OPCODE);

  link_state_e            state_q;
  logic [CRD_W-1:0]       crd_q, crd_d;
  logic                   ovf_q, ovf_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   flitv_q;
  logic [FLIT_W-1:0]      flit_q, win_flit;
  logic [NUM_ENTRIES-1:0] gnt;
  logic [IDX_W-1:0]       win_idx;
  logic                   crd_nz, grant_en, accept, crd_ret, send, lcrd_in;

  assign crd_nz   = (crd_q != '0);
  assign grant_en = (state_q == RUN) && crd_nz;
  assign crd_ret  = (state_q == DEACTIVATE) && crd_nz;
  assign accept   = |gnt;
  assign send     = accept | crd_ret;
  assign lcrd_in  = txreq_lcrdv && (state_q != STOP);

  rr_arbiter #(.NUM_ENTRIES(NUM_ENTRIES)) u_arb (
    .req_i (entry_txreq_valid),
    .ptr_i (rr_ptr_q),
    .en_i  (grant_en),
    .gnt_o (gnt),
    .idx_o (win_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STOP;
    end else begin
      unique case (state_q)
        STOP:       if (link_en && !txlinkactiveack) state_q <= ACTIVATE;
        ACTIVATE:   if (txlinkactiveack) state_q <= link_en ? RUN : DEACTIVATE;
        RUN:        if (!link_en) state_q <= DEACTIVATE;
        DEACTIVATE: if (!txlinkactiveack && !crd_nz) state_q <= STOP;
        default:    state_q <= STOP;
      endcase
    end
  end

  // A credit arriving alongside a send nets to zero, so it can never overflow.
  always_comb begin
    crd_d = crd_q;
    ovf_d = ovf_q;
    if (send && !lcrd_in) begin
      crd_d = crd_q - CRD_W'(1);
    end else if (lcrd_in && !send) begin
      if (crd_q == CRD_W'(MAX_CRD)) ovf_d = 1'b1;
      else                          crd_d = crd_q + CRD_W'(1);
    end
  end

  always_comb begin
    win_flit = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (win_idx == IDX_W'(i)) win_flit = entry_txreq_flit[i*FLIT_W +: FLIT_W];
    end
    win_flit[TXNID_LSB +: TXNID_W] = TXNID_W'(win_idx);
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (win_idx == IDX_W'(NUM_ENTRIES - 1)) ? '0 : win_idx + IDX_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crd_q    <= '0;
      ovf_q    <= 1'b0;
      rr_ptr_q <= '0;
      flitv_q  <= 1'b0;
      flit_q   <= '0;
    end else begin
      crd_q    <= crd_d;
      ovf_q    <= ovf_d;
      rr_ptr_q <= rr_ptr_d;
      flitv_q  <= send;
      if (accept)       flit_q <= win_flit;
      else if (crd_ret) flit_q <= RET_FLIT;
    end
  end

  assign entry_txreq_ready = gnt;
  assign txreq_flitv       = flitv_q;
  assign txreq_flit        = flit_q;
  assign txreq_flitpend    = ((state_q == RUN) && |entry_txreq_valid) || crd_ret;
  assign txlinkactivereq   = (state_q == ACTIVATE) || (state_q == RUN);
  assign link_run          = (state_q == RUN);
  assign crd_overflow      = ovf_q;

endmodule

// File: tb/tb_tl2chi_txreq_sched.sv
// tb/tb_tl2chi_txreq_sched.sv - self-checking bench for tl2chi_txreq_sched
module tb_tl2chi_txreq_sched;

  localparam int N   = 4;
  localparam int FW  = 100;
  localparam int LSB = 4;

  logic clk = 1'b0, reset = 1'b1, link_en = 1'b0, lcrdv = 1'b0, ack = 1'b0;
  logic [N-1:0]    valid = '0;
  logic [FW-1:0]   ef [N];
  logic [N*FW-1:0] eflit;
  logic [N-1:0]    ready;
  logic            flitpend, flitv, lreq, lrun, ovf;
  logic [FW-1:0]   flit;

  int checks = 0, errors = 0;

  // Spec-level model: state 0=STOP 1=ACTIVATE 2=RUN 3=DEACTIVATE
  int            m_st, m_crd, m_ptr;
  bit            m_ovf, m_flitv;
  logic [FW-1:0] m_flit;

  int rr_exp [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  tl2chi_txreq_sched dut (
    .clk               (clk),
    .reset             (reset),
    .link_en           (link_en),
    .entry_txreq_valid (valid),
    .entry_txreq_flit  (eflit),
    .entry_txreq_ready (ready),
    .txreq_flitpend    (flitpend),
    .txreq_flitv       (flitv),
    .txreq_flit        (flit),
    .txreq_lcrdv       (lcrdv),
    .txlinkactivereq   (lreq),
    .txlinkactiveack   (ack),
    .link_run          (lrun),
    .crd_overflow      (ovf)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) eflit[i*FW +: FW] = ef[i];
  end

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int            w;
    bit            ret, snd, lc;
    logic [N-1:0]  er;
    logic [FW-1:0] nf;
    if (reset) begin
      m_st = 0; m_crd = 0; m_ptr = 0; m_ovf = 0; m_flitv = 0; m_flit = '0;
    end
    w   = (m_st == 2 && m_crd > 0) ? pick(valid, m_ptr) : -1;
    ret = (m_st == 3 && m_crd > 0);
    er  = '0;
    if (w >= 0) er[w] = 1'b1;
    chk("m_ready",    FW'(ready),      FW'(er));
    chk("m_flitpend", FW'(flitpend),   FW'((m_st == 2 && valid != '0) || ret));
    chk("m_flitv",    FW'(flitv),      FW'(m_flitv));
    chk("m_flit",     flit,            m_flit);
    chk("m_req",      FW'(lreq),       FW'(m_st == 1 || m_st == 2));
    chk("m_run",      FW'(lrun),       FW'(m_st == 2));
    chk("m_ovf",      FW'(ovf),        FW'(m_ovf));
    chk("m_crd",      FW'(dut.crd_q),  FW'(m_crd));
    chk("m_ptr",      FW'(dut.rr_ptr_q), FW'(m_ptr));
    if (!reset) begin
      snd = (w >= 0) || ret;
      lc  = lcrdv && (m_st != 0);
      case (m_st)
        0: if (link_en && !ack) m_st = 1;
        1: if (ack) m_st = link_en ? 2 : 3;
        2: if (!link_en) m_st = 3;
        default: if (!ack && m_crd == 0) m_st = 0;
      endcase
      if (snd && !lc) m_crd--;
      else if (lc && !snd) begin
        if (m_crd == 15) m_ovf = 1;
        else m_crd++;
      end
      if (w >= 0) begin
        nf = ef[w];
        nf[LSB +: 8] = 8'(w);
        m_flit = nf; m_flitv = 1; m_ptr = (w + 1) % N;
      end else if (ret) begin
        m_flit = '0; m_flitv = 1;
      end else begin
        m_flitv = 0;
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      ef[i] = FW'({$urandom(), $urandom(), $urandom(), $urandom()});
      ef[i][LSB +: 8] = 8'hA5;
    end

    // reset and bring-up
    repeat (2) tick();
    chk("rst_flitv", FW'(flitv), FW'(0));
    chk("rst_req",   FW'(lreq),  FW'(0));
    chk("rst_crd",   FW'(dut.crd_q), FW'(0));
    reset = 0; link_en = 1; valid = 4'hF;
    tick();
    chk("up_req",   FW'(lreq),  FW'(1));
    chk("up_ready", FW'(ready), FW'(0));
    tick(); tick(); ack = 1;
    tick();
    chk("up_run",       FW'(lrun),  FW'(1));
    chk("up_nocrd_rdy", FW'(ready), FW'(0));

    // credit gating: two credits, second arrives with the first grant
    lcrdv = 1; #1;
    chk("cg_rdy0", FW'(ready), FW'(0));
    tick(); #1;
    chk("cg_rdy1", FW'(ready), FW'(4'b0001));
    tick();
    chk("cg_crd_same", FW'(dut.crd_q), FW'(1));
    chk("cg_flitv0",   FW'(flitv), FW'(1));
    chk("cg_txnid0",   FW'(flit[LSB +: 8]), FW'(0));
    lcrdv = 0; #1;
    chk("cg_rdy2", FW'(ready), FW'(4'b0010));
    tick();
    chk("cg_txnid1", FW'(flit[LSB +: 8]), FW'(1));
    #1 chk("cg_stall", FW'(ready), FW'(0));
    tick();
    chk("cg_idle_flitv", FW'(flitv), FW'(0));
    lcrdv = 1; #1;
    chk("cg_new_crd_unusable", FW'(ready), FW'(0));
    tick();
    lcrdv = 0; #1;
    chk("cg_rdy3", FW'(ready), FW'(4'b0100));
    tick();
    chk("cg_txnid2", FW'(flit[LSB +: 8]), FW'(2));
    valid = 0;

    // round robin: 9 credits, entry 3 alone first so the sweep starts at 0
    lcrdv = 1; repeat (9) tick(); lcrdv = 0;
    valid = 4'b1000; #1;
    chk("rr_pre", FW'(ready), FW'(4'b1000));
    tick();
    valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1 chk("rr_ready", FW'(ready), FW'(4'b0001 << rr_exp[k]));
      tick();
      chk("rr_flitv", FW'(flitv), FW'(1));
      chk("rr_txnid", FW'(flit[LSB +: 8]), FW'(rr_exp[k]));
    end
    #1 chk("rr_exhausted", FW'(ready), FW'(0));
    valid = 0;

    // overflow at MAX_CRD
    lcrdv = 1; repeat (15) tick();
    chk("ov_crd15", FW'(dut.crd_q), FW'(15));
    chk("ov_clear", FW'(ovf), FW'(0));
    tick(); lcrdv = 0;
    chk("ov_crd_hold", FW'(dut.crd_q), FW'(15));
    chk("ov_set",      FW'(ovf), FW'(1));
    valid = 4'b0001; repeat (12) tick(); valid = 0;
    chk("ov_spent", FW'(dut.crd_q), FW'(3));

    // teardown with three credits outstanding
    link_en = 0;
    tick();
    chk("td_req", FW'(lreq), FW'(0));
    valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1 chk("td_ready", FW'(ready), FW'(0));
      chk("td_pend", FW'(flitpend), FW'(1));
      tick();
      chk("td_flitv", FW'(flitv), FW'(1));
      chk("td_flit0", flit, FW'(0));
    end
    chk("td_crd0", FW'(dut.crd_q), FW'(0));
    #1 chk("td_pend0", FW'(flitpend), FW'(0));
    tick();
    chk("td_flitv0", FW'(flitv), FW'(0));
    ack = 0; valid = 0;
    tick();
    link_en = 1;
    tick();
    chk("td_restart_req", FW'(lreq), FW'(1));
    ack = 1;
    tick();

    // reset with a flit in flight
    lcrdv = 1; repeat (3) tick(); lcrdv = 0;
    valid = 4'hF; #1;
    chk("mr_rdy", FW'(ready), FW'(4'b0010));
    tick();
    chk("mr_inflight", FW'(flitv), FW'(1));
    #1 reset = 1; #1;
    chk("mr_flitv", FW'(flitv), FW'(0));
    chk("mr_ready", FW'(ready), FW'(0));
    chk("mr_req",   FW'(lreq),  FW'(0));
    chk("mr_crd",   FW'(dut.crd_q), FW'(0));
    chk("mr_ptr",   FW'(dut.rr_ptr_q), FW'(0));
    repeat (2) tick();
    reset = 0; ack = 0; link_en = 1;
    tick();
    ack = 1;
    tick();
    lcrdv = 1;
    tick();
    lcrdv = 0; #1;
    chk("mr_first_grant", FW'(ready), FW'(4'b0001));
    tick();
    chk("mr_txnid", FW'(flit[LSB +: 8]), FW'(0));
    valid = 0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
